fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction register.
- Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words and presents one word per cycle on `ir_data`/`ir_load`; `ir_load` and `ir_data` connect straight to the instruction register's `load`/`in`.
- Supports branch redirect with flush, and halt.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack sequencing and a small word buffer that feeds
// the instruction register. Define FETCH_PREFETCH_EN for a 2-entry buffer (default 1 entry).
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ir_ready,
    output logic              ir_load,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    typedef enum logic {StIdle, StReq} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                drop_q, drop_d;
    logic [1:0]          count_q, count_d;
    logic [DATA_W-1:0]   word0_q;
    logic [ADDR_W-1:0]   pc0_q;
`ifdef FETCH_PREFETCH_EN
    logic [DATA_W-1:0]   word1_q;
    logic [ADDR_W-1:0]   pc1_q;
`endif
    logic                push, pop, issue;

    assign mem_req  = (state_q == StReq);
    assign mem_addr = addr_q;
    assign ir_load  = (count_q != 2'd0) && ir_ready && !redirect;
    assign ir_data  = word0_q;
    assign ir_pc    = pc0_q;
    assign pop      = ir_load;
    // Acks of a flushed request, or acks landing on a redirect, never reach the buffer.
    assign push     = mem_req && mem_ack && !drop_q && !redirect;

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // A new request may start only if a slot is free after this edge's push/pop.
    assign issue = !halt && !redirect && (count_d < DEPTH);

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StReq;
            end
            StReq: begin
                if (mem_ack) begin
                    drop_d  = 1'b0;
                    state_d = issue ? StReq : StIdle;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
            count_q <= 2'd0;
            word0_q <= '0;
            pc0_q   <= '0;
`ifdef FETCH_PREFETCH_EN
            word1_q <= '0;
            pc1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            // The address is frozen while a request waits for its ack.
            if (state_q != StReq || mem_ack) begin
                addr_q <= pc_d;
            end
`ifdef FETCH_PREFETCH_EN
            if (pop) begin
                word0_q <= word1_q;
                pc0_q   <= pc1_q;
            end
            if (push) begin
                if (count_q == 2'd0 || pop) begin
                    word0_q <= mem_rdata;
                    pc0_q   <= addr_q;
                end else begin
                    word1_q <= mem_rdata;
                    pc1_q   <= addr_q;
                end
            end
`else
            if (push) begin
                word0_q <= mem_rdata;
                pc0_q   <= addr_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for zero-wait streaming, plus directed
// sequences for wait states, back-pressure, redirect and halt.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_ready;
    logic        ir_load;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Memory model: data = A000 + addr, ack after 'waits' stall cycles, optional address block.
    int          waits   = 0;
    int          wcnt    = 0;
    logic        blk     = 1'b0;
    logic [15:0] blk_addr = 16'h0005;

    logic [31:0] loads[$];
    logic [15:0] acks[$];
    int          lens[$];
    int          cur_len = 0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = 16'h0;

    always #5 clk = ~clk;

    assign mem_rdata = 16'hA000 + mem_addr;
    assign mem_ack   = mem_req && (wcnt >= waits) && !(blk && (mem_addr == blk_addr));

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_ready    (ir_ready),
        .ir_load     (ir_load),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Monitor: record loads/acks and check that a pending request stays put.
    always @(negedge clk) begin
        if (rst) begin
            prev_pend <= 1'b0;
            cur_len   <= 0;
        end else begin
            if (prev_pend) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("addr_held", 32'(mem_addr), 32'(prev_addr));
            end
            prev_pend <= mem_req && !mem_ack;
            prev_addr <= mem_addr;
            if (ir_load) loads.push_back({ir_data, ir_pc});
            if (mem_req && mem_ack && !redirect) acks.push_back(mem_addr);
            if (!mem_req) begin
                cur_len <= 0;
            end else if (mem_ack) begin
                lens.push_back(cur_len + 1);
                cur_len <= 0;
            end else begin
                cur_len <= cur_len + 1;
            end
        end
    end

    task automatic begin_reset(input logic rdy, input int w);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        halt        = 1'b0;
        ir_ready    = rdy;
        waits       = w;
        blk         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_reset;
        @(posedge clk);
        #1;
        rst = 1'b0;
        loads.delete();
        acks.delete();
        lens.delete();
    endtask

    task automatic wait_loads(input string name, input int n, input int budget);
        int c = 0;
        while (loads.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(name, 32'(loads.size() >= n), 32'd1);
    endtask

    task automatic wait_req_addr(input string name, input logic [15:0] a, input int budget);
        int c = 0;
        while (!(mem_req && mem_addr == a) && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(name, 32'(mem_req && mem_addr == a), 32'd1);
    endtask

    task automatic check_load(input string name, input int idx, input logic [15:0] pc);
        logic [15:0] d;
        d = 16'hA000 + pc;
        check(name, (idx < loads.size()) ? loads[idx] : 32'hDEAD_DEAD, {d, pc});
    endtask

    typedef struct {
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        load;
        logic [15:0] data;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
`ifdef FETCH_PREFETCH_EN
        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'hA000, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'hA001, 16'h0001};
        vecs[3] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'hA002, 16'h0002};
        vecs[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'hA003, 16'h0003};
        vecs[5] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'hA004, 16'h0004};
        vecs[6] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'hA005, 16'h0005};
        vecs[7] = '{1'b1, 1'b1, 16'h0007, 1'b1, 16'hA006, 16'h0006};
`else
        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hA000, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hA001, 16'h0001};
        vecs[4] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hA002, 16'h0002};
        vecs[6] = '{1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hA003, 16'h0003};
`endif

        // Reset state and zero-wait streaming, cycle by cycle.
        begin_reset(1'b1, 0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ir_load", 32'(ir_load), 32'd0);
        check("rst_ir_data", 32'(ir_data), 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        end_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            ir_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].req));
            if (vecs[i].req) check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_load", i), 32'(ir_load), 32'(vecs[i].load));
            if (vecs[i].load) begin
                check($sformatf("vec%0d_data", i), 32'(ir_data), 32'(vecs[i].data));
                check($sformatf("vec%0d_pc", i), 32'(ir_pc), 32'(vecs[i].pc));
            end
        end

        // Three wait states: each request held for 4 cycles, words delivered once each.
        begin_reset(1'b1, 3);
        end_reset();
        wait_loads("ws_loads", 4, 80);
        for (int i = 0; i < 4; i++) begin
            check_load($sformatf("ws_load%0d", i), i, 16'(i));
            check($sformatf("ws_len%0d", i), 32'((i < lens.size()) ? lens[i] : -1), 32'd4);
        end

        // Back-pressure: buffer fills, requests stop, then drains in order.
        begin_reset(1'b0, 0);
        end_reset();
        repeat (10) @(posedge clk);
        #1;
        check("bp_acks", 32'(acks.size()), 32'(DEPTH));
        check("bp_req_low", 32'(mem_req), 32'd0);
        check("bp_no_load", 32'(loads.size()), 32'd0);
        ir_ready = 1'b1;
        wait_loads("bp_loads", 4, 40);
        for (int i = 0; i < 4; i++) check_load($sformatf("bp_load%0d", i), i, 16'(i));

        // Redirect while the request to 0x0005 waits on its ack.
        begin_reset(1'b1, 0);
        blk_addr = 16'h0005;
        blk      = 1'b1;
        end_reset();
        wait_req_addr("rd_reach5", 16'h0005, 40);
        repeat (3) @(posedge clk);
        #1;
        loads.delete();
        acks.delete();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        blk      = 1'b0;
        wait_loads("rd_loads", 2, 40);
        check("rd_ack0", 32'((acks.size() > 0) ? acks[0] : 16'hDEAD), 32'h0005);
        check("rd_ack1", 32'((acks.size() > 1) ? acks[1] : 16'hDEAD), 32'h0040);
        check_load("rd_load0", 0, 16'h0040);
        check_load("rd_load1", 1, 16'h0041);

        // Redirect to the top of the address space: wraps to 0x0000.
        begin_reset(1'b1, 0);
        end_reset();
        repeat (5) @(posedge clk);
        #1;
        loads.delete();
        acks.delete();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_loads("wrap_loads", 2, 40);
        check("wrap_ack0", 32'((acks.size() > 0) ? acks[0] : 16'hDEAD), 32'hFFFF);
        check("wrap_ack1", 32'((acks.size() > 1) ? acks[1] : 16'hDEAD), 32'h0000);
        check_load("wrap_load0", 0, 16'hFFFF);
        check_load("wrap_load1", 1, 16'h0000);

        // Halt mid-request: outstanding word delivered, nothing more until release.
        begin_reset(1'b1, 3);
        end_reset();
        wait_req_addr("halt_reach2", 16'h0002, 60);
        @(posedge clk);
        #1;
        halt = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("halt_acks", 32'(acks.size()), 32'd3);
        check("halt_loads", 32'(loads.size()), 32'd3);
        check("halt_req_low", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) check_load($sformatf("halt_load%0d", i), i, 16'(i));
        halt = 1'b0;
        wait_loads("resume_loads", 4, 40);
        check("resume_ack", 32'((acks.size() > 3) ? acks[3] : 16'hDEAD), 32'h0003);
        check_load("resume_load", 3, 16'h0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
